hms_merge_node: RTL and testbench
=================================

HMS_MERGE_NODE -- requirements
Module: hms_merge_node

Interface
REQ-001 Parameter FIFO_LOG, default 2, log2 of per-input FIFO depth (DEPTH = 1<<FIFO_LOG, FIFO_LOG >= 1).
REQ-002 Parameter FLOAT, default "no", "yes" compares keys as IEEE-754 single/double patterns.
REQ-003 Parameter SIGNED, default "no", "yes" compares keys as two's complement; ignored when FLOAT = "yes".
REQ-004 Parameter ASCEND, default 1, 1 = smallest key first, 0 = largest key first.
REQ-005 Parameter DATW, default 64, record width; parameter KEYW, default 32, key = DIN[KEYW-1:0], KEYW <= DATW.
REQ-006 Parameter CNTW, default 32, width of record counter.
REQ-007 CLK  in  1  single clock; all logic on rising edge.
REQ-008 RST  in  1  reset, synchronous, active-high.
REQ-009 IN_FULL  in  1  downstream back-pressure; 1 = do not issue a new record.
REQ-010 DIN_A / DIN_B  in  DATW  input records, streams A and B.
REQ-011 DINEN_A / DINEN_B  in  1  write strobe for DIN_A / DIN_B.
REQ-012 FULL_A / FULL_B  out  1  registered almost-full back-pressure to upstream.
REQ-013 DOT  out  DATW  merged output record; DOTEN  out  1  DOT valid strobe.
REQ-014 DONE  out  1  one-cycle pulse when a merged run is terminated.
REQ-015 OVF  out  1  sticky flag, a write was dropped on a full FIFO.
REQ-016 REC_CNT  out  CNTW  non-sentinel records emitted since reset.

Function
REQ-017 Each input SHALL have its own DEPTH-entry FIFO; a write with DINEN_x=1 is stored at the rising edge if occupancy < DEPTH.
REQ-018 FULL_x SHALL be registered and SHALL be 1 in the cycle after occupancy reaches >= DEPTH-1 (one slot of slack for upstream latency).
REQ-019 A write when occupancy == DEPTH and no pop in the same cycle SHALL be dropped and set OVF until reset; a simultaneous write and pop at DEPTH SHALL be accepted.
REQ-020 Sentinel key: all-ones after key transform when ASCEND=1, all-zeros after transform when ASCEND=0; it marks end of run on a stream.
REQ-021 Key transform: FLOAT -> sign=1 invert all bits, sign=0 invert sign bit only; SIGNED -> invert MSB; else identity; comparison is unsigned on transformed keys.
REQ-022 Issue condition: IN_FULL=0 and both FIFOs non-empty; otherwise no pop and DOTEN=0 next cycle (a side never wins by absence).
REQ-023 Selection: neither head sentinel -> emit head with smaller (ASCEND=1) / larger (ASCEND=0) transformed key, tie -> A; pop the chosen FIFO only.
REQ-024 One head sentinel -> emit and pop the other head; sentinel stays at the FIFO head.
REQ-025 Both heads sentinel -> emit one sentinel record (A's), pop both FIFOs, pulse DONE in the same cycle as that DOTEN.
REQ-026 Output SHALL be registered: DOT/DOTEN update one cycle after the issue decision; minimum input-to-output latency 2 cycles (write at t, visible at t+1, DOTEN at t+2).
REQ-027 DOT SHALL hold its last value when DOTEN=0.
REQ-028 REC_CNT SHALL increment by 1 with each non-sentinel DOTEN, wrapping modulo 2^CNTW; sentinel outputs do not count.
REQ-029 Throughput: one record per cycle sustained when both FIFOs stay non-empty and IN_FULL=0.
REQ-030 IN_FULL rising SHALL stop issue in that same cycle; at most zero records are emitted after the cycle IN_FULL is sampled high.

Reset
REQ-031 On RST=1 at a rising edge: FIFO occupancies 0, DOT 0, DOTEN 0, FULL_A/B 0, DONE 0, OVF 0, REC_CNT 0.
REQ-032 Reset mid-operation SHALL discard all buffered records; writes presented during RST=1 are ignored.
REQ-033 First write is accepted on the first edge with RST=0.

Verification
REQ-034 Ascending unsigned: A=1,4,9,FFFFFFFF; B=2,3,10,FFFFFFFF -> DOT keys 1,2,3,4,9,10,FFFFFFFF; DONE once with sentinel; REC_CNT=6.
REQ-035 SIGNED="yes": A=-5(FFFFFFFB),7; B=0,3 then sentinels (7FFFFFFF raw) -> order -5,0,3,7, sentinel; tie A=B=3 -> A's payload first.
REQ-036 FLOAT="yes": keys -1.0,-0.5,0.25,2.0 split across A/B -> ascending order preserved; ASCEND=0 reverses it.
REQ-037 Back-pressure: IN_FULL=1 for 5 cycles mid-stream -> DOTEN=0 throughout, no record lost or duplicated, output resumes 1 cycle after IN_FULL falls.
REQ-038 Overflow: FIFO_LOG=2, 5 writes to A with B empty -> FULL_A=1 after 3rd write, 5th write dropped, OVF=1, A holds first 4.
REQ-039 RST pulse with both FIFOs holding 3 records -> next cycle all outputs 0, subsequent merge starts clean.

Source files
------------

// File: rtl/hms_merge_node.sv
// Two-input sorted-run merge: per-input FIFOs, keyed head selection, registered output.
// Write-to-DOTEN latency 2 cycles; IN_FULL blocks issue in the same cycle, FULL_x asserts one slot early.
module hms_merge_node #(
  parameter int    FIFO_LOG = 2,
  parameter string FLOAT    = "no",
  parameter string SIGNED   = "no",
  parameter int    ASCEND   = 1,
  parameter int    DATW     = 64,
  parameter int    KEYW     = 32,
  parameter int    CNTW     = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_FULL,
  input  logic [DATW-1:0] DIN_A,
  input  logic [DATW-1:0] DIN_B,
  input  logic            DINEN_A,
  input  logic            DINEN_B,
  output logic            FULL_A,
  output logic            FULL_B,
  output logic [DATW-1:0] DOT,
  output logic            DOTEN,
  output logic            DONE,
  output logic            OVF,
  output logic [CNTW-1:0] REC_CNT
);
  localparam int DEPTH     = 1 << FIFO_LOG;
  localparam bit IS_FLOAT  = (FLOAT == "yes");
  localparam bit IS_SIGNED = (SIGNED == "yes");
  localparam bit ASC       = (ASCEND != 0);
  localparam logic [FIFO_LOG-1:0] P_ONE    = FIFO_LOG'(1);
  localparam logic [FIFO_LOG:0]   C_ONE    = (FIFO_LOG+1)'(1);
  localparam logic [FIFO_LOG:0]   C_DEPTH  = (FIFO_LOG+1)'(DEPTH);
  localparam logic [FIFO_LOG:0]   C_ALMOST = (FIFO_LOG+1)'(DEPTH-1);
  localparam logic [CNTW-1:0]     R_ONE    = CNTW'(1);
  localparam logic [KEYW-1:0]     MSB      = KEYW'(1) << (KEYW-1);
  localparam logic [KEYW-1:0]     SENT     = {KEYW{ASC}};

  // Map keys so that a plain unsigned compare gives the requested order.
  function automatic logic [KEYW-1:0] xform(input logic [KEYW-1:0] k);
    logic [KEYW-1:0] r;
    r = k;
    if (IS_FLOAT) r = k[KEYW-1] ? ~k : (k ^ MSB);
    else if (IS_SIGNED) r = k ^ MSB;
    return r;
  endfunction

  logic [DATW-1:0] din  [2];
  logic [DATW-1:0] head [2];
  logic [1:0]      wen, pop, nempty, full, drop;

  assign din[0] = DIN_A;
  assign din[1] = DIN_B;
  assign wen    = {DINEN_B, DINEN_A};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATW-1:0]     mem [DEPTH];
    logic [FIFO_LOG-1:0] wp, rp;
    logic [FIFO_LOG:0]   cnt, cnt_nxt;
    logic                wr_ok, full_q;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_ok = wen[g] && ((cnt != C_DEPTH) || pop[g]);
    assign drop[g] = wen[g] && (cnt == C_DEPTH) && !pop[g];

    always_comb begin
      cnt_nxt = cnt;
      if (wr_ok)  cnt_nxt = cnt_nxt + C_ONE;
      if (pop[g]) cnt_nxt = cnt_nxt - C_ONE;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        wp     <= '0;
        rp     <= '0;
        cnt    <= '0;
        full_q <= 1'b0;
      end else begin
        if (wr_ok) begin
          mem[wp] <= din[g];
          wp      <= wp + P_ONE;
        end
        if (pop[g]) rp <= rp + P_ONE;
        cnt    <= cnt_nxt;
        full_q <= (cnt_nxt >= C_ALMOST);
      end
    end

    assign head[g]   = mem[rp];
    assign nempty[g] = (cnt != '0);
    assign full[g]   = full_q;
  end

  assign FULL_A = full[0];
  assign FULL_B = full[1];

  logic [KEYW-1:0] ka, kb;
  logic            sa, sb, a_wins, issue;
  logic [DATW-1:0] sel_dat;

  assign ka     = xform(head[0][KEYW-1:0]);
  assign kb     = xform(head[1][KEYW-1:0]);
  assign sa     = (ka == SENT);
  assign sb     = (kb == SENT);
  assign issue  = !IN_FULL && nempty[0] && nempty[1];
  assign a_wins = ASC ? (ka <= kb) : (ka >= kb);

  // A sentinel head parks its stream until the other side reaches its own sentinel.
  always_comb begin
    pop     = 2'b00;
    sel_dat = head[0];
    if (issue) begin
      if (sa && sb) begin
        pop = 2'b11;
      end else if (sa || (!sb && !a_wins)) begin
        pop     = 2'b10;
        sel_dat = head[1];
      end else begin
        pop = 2'b01;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOT     <= '0;
      DOTEN   <= 1'b0;
      DONE    <= 1'b0;
      OVF     <= 1'b0;
      REC_CNT <= '0;
    end else begin
      DOTEN <= issue;
      DONE  <= issue && sa && sb;
      if (issue) DOT <= sel_dat;
      if (issue && !(sa && sb)) REC_CNT <= REC_CNT + R_ONE;
      if (|drop) OVF <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hms_merge_node.sv
// Directed bench for hms_merge_node: four parameter variants share stimulus; a queue holds expected records.
module tb_hms_merge_node;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_full, dinen_a, dinen_b;
  logic [63:0] din_a, din_b;
  logic [63:0] dot_v [4];
  logic [31:0] cnt_v [4];
  logic [3:0]  doten_v, done_v, ovf_v, fa_v, fb_v;

  hms_merge_node u_uns (
    .CLK(clk), .RST(rst), .IN_FULL(in_full), .DIN_A(din_a), .DIN_B(din_b),
    .DINEN_A(dinen_a), .DINEN_B(dinen_b), .FULL_A(fa_v[0]), .FULL_B(fb_v[0]),
    .DOT(dot_v[0]), .DOTEN(doten_v[0]), .DONE(done_v[0]), .OVF(ovf_v[0]), .REC_CNT(cnt_v[0]));

  hms_merge_node #(.SIGNED("yes")) u_sgn (
    .CLK(clk), .RST(rst), .IN_FULL(in_full), .DIN_A(din_a), .DIN_B(din_b),
    .DINEN_A(dinen_a), .DINEN_B(dinen_b), .FULL_A(fa_v[1]), .FULL_B(fb_v[1]),
    .DOT(dot_v[1]), .DOTEN(doten_v[1]), .DONE(done_v[1]), .OVF(ovf_v[1]), .REC_CNT(cnt_v[1]));

  hms_merge_node #(.FLOAT("yes")) u_fup (
    .CLK(clk), .RST(rst), .IN_FULL(in_full), .DIN_A(din_a), .DIN_B(din_b),
    .DINEN_A(dinen_a), .DINEN_B(dinen_b), .FULL_A(fa_v[2]), .FULL_B(fb_v[2]),
    .DOT(dot_v[2]), .DOTEN(doten_v[2]), .DONE(done_v[2]), .OVF(ovf_v[2]), .REC_CNT(cnt_v[2]));

  hms_merge_node #(.FLOAT("yes"), .ASCEND(0)) u_fdn (
    .CLK(clk), .RST(rst), .IN_FULL(in_full), .DIN_A(din_a), .DIN_B(din_b),
    .DINEN_A(dinen_a), .DINEN_B(dinen_b), .FULL_A(fa_v[3]), .FULL_B(fb_v[3]),
    .DOT(dot_v[3]), .DOTEN(doten_v[3]), .DONE(done_v[3]), .OVF(ovf_v[3]), .REC_CNT(cnt_v[3]));

  typedef struct packed {
    logic [63:0] dot;
    logic        done;
  } exp_t;

  localparam logic [31:0] HA = 32'hAAAA_0000;
  localparam logic [31:0] HB = 32'hBBBB_0000;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sel   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Advance one clock and score whatever the selected instance emitted.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (doten_v[sel]) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_record: observed %h expected no output", dot_v[sel]);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dot", dot_v[sel], e.dot);
        chk("done", {63'b0, done_v[sel]}, {63'b0, e.done});
      end
    end else begin
      chk("done_idle", {63'b0, done_v[sel]}, 64'b0);
    end
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] key, input logic done);
    exp_q.push_back({hi, key, done});
  endtask

  task automatic wr(input logic ea, input logic [31:0] ka, input logic eb, input logic [31:0] kb);
    din_a   = {HA, ka};
    din_b   = {HB, kb};
    dinen_a = ea;
    dinen_b = eb;
    tick();
    dinen_a = 1'b0;
    dinen_b = 1'b0;
  endtask

  task automatic drain(input int n_recs);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
    exp_q.delete();
    repeat (4) tick();
    chk("rec_cnt", {32'b0, cnt_v[sel]}, 64'(n_recs));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_full = 1'b0;
    dinen_a = 1'b0;
    dinen_b = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_full = 1'b0; dinen_a = 1'b0; dinen_b = 1'b0;
    din_a = '0; din_b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_dot", dot_v[0], 64'h0);
    chk("rst_doten", {63'b0, doten_v[0]}, 64'h0);
    chk("rst_ovf", {63'b0, ovf_v[0]}, 64'h0);
    chk("rst_full_a", {63'b0, fa_v[0]}, 64'h0);
    chk("rst_full_b", {63'b0, fb_v[0]}, 64'h0);
    chk("rst_cnt", {32'b0, cnt_v[0]}, 64'h0);

    // Ascending unsigned merge
    sel = 0;
    push(HA, 32'd1, 0); push(HB, 32'd2, 0); push(HB, 32'd3, 0); push(HA, 32'd4, 0);
    push(HA, 32'd9, 0); push(HB, 32'd10, 0); push(HA, 32'hFFFF_FFFF, 1);
    wr(1, 32'd1, 1, 32'd2);
    wr(1, 32'd4, 1, 32'd3);
    wr(1, 32'd9, 1, 32'd10);
    wr(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    drain(6);

    // Signed keys, with an A/B tie on 3
    do_reset();
    sel = 1;
    push(HA, 32'hFFFF_FFFB, 0); push(HB, 32'd0, 0); push(HA, 32'd3, 0); push(HB, 32'd3, 0);
    push(HA, 32'd7, 0); push(HA, 32'h7FFF_FFFF, 1);
    wr(1, 32'hFFFF_FFFB, 1, 32'd0);
    wr(1, 32'd3, 1, 32'd3);
    wr(1, 32'd7, 1, 32'h7FFF_FFFF);
    wr(1, 32'h7FFF_FFFF, 0, 32'd0);
    drain(5);

    // Float ascending: -1.0, -0.5, 0.25, 2.0
    do_reset();
    sel = 2;
    push(HA, 32'hBF80_0000, 0); push(HB, 32'hBF00_0000, 0); push(HA, 32'h3E80_0000, 0);
    push(HB, 32'h4000_0000, 0); push(HA, 32'h7FFF_FFFF, 1);
    wr(1, 32'hBF80_0000, 1, 32'hBF00_0000);
    wr(1, 32'h3E80_0000, 1, 32'h4000_0000);
    wr(1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF);
    drain(4);

    // Float descending: 2.0, 0.25, -0.5, -1.0
    do_reset();
    sel = 3;
    push(HA, 32'h4000_0000, 0); push(HB, 32'h3E80_0000, 0); push(HA, 32'hBF00_0000, 0);
    push(HB, 32'hBF80_0000, 0); push(HA, 32'hFFFF_FFFF, 1);
    wr(1, 32'h4000_0000, 1, 32'h3E80_0000);
    wr(1, 32'hBF00_0000, 1, 32'hBF80_0000);
    wr(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    drain(4);

    // Back-pressure mid-stream
    do_reset();
    sel = 0;
    push(HA, 32'd10, 0); push(HB, 32'd15, 0); push(HA, 32'd20, 0); push(HB, 32'd25, 0);
    push(HA, 32'd30, 0); push(HB, 32'd35, 0); push(HA, 32'hFFFF_FFFF, 1);
    in_full = 1'b1;
    wr(1, 32'd10, 1, 32'd15);
    wr(1, 32'd20, 1, 32'd25);
    wr(1, 32'd30, 1, 32'd35);
    wr(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    in_full = 1'b0;
    tick();
    tick();
    in_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_doten", {63'b0, doten_v[0]}, 64'h0);
    end
    in_full = 1'b0;
    tick();
    chk("bp_resume", {63'b0, doten_v[0]}, 64'h1);
    drain(6);

    // Overflow on A with B empty
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr(1, 32'(i), 0, 32'd0);
      if (i == 2) chk("full_a_2", {63'b0, fa_v[0]}, 64'h0);
      if (i == 3) chk("full_a_3", {63'b0, fa_v[0]}, 64'h1);
      if (i == 4) chk("ovf_4", {63'b0, ovf_v[0]}, 64'h0);
      if (i == 5) chk("ovf_5", {63'b0, ovf_v[0]}, 64'h1);
    end
    push(HA, 32'd1, 0); push(HA, 32'd2, 0); push(HA, 32'd3, 0); push(HA, 32'd4, 0);
    wr(0, 32'd0, 1, 32'hFFFF_FFFF);
    drain(4);

    // Reset with records buffered on both sides and writes presented during reset
    in_full = 1'b1;
    wr(1, 32'd50, 1, 32'd55);
    wr(1, 32'd60, 1, 32'd65);
    wr(1, 32'd70, 1, 32'd75);
    rst = 1'b1;
    din_a = {HA, 32'd99}; din_b = {HB, 32'd99};
    dinen_a = 1'b1; dinen_b = 1'b1;
    tick();
    rst = 1'b0; dinen_a = 1'b0; dinen_b = 1'b0;
    chk("rst2_dot", dot_v[0], 64'h0);
    chk("rst2_doten", {63'b0, doten_v[0]}, 64'h0);
    chk("rst2_ovf", {63'b0, ovf_v[0]}, 64'h0);
    chk("rst2_full_a", {63'b0, fa_v[0]}, 64'h0);
    chk("rst2_full_b", {63'b0, fb_v[0]}, 64'h0);
    chk("rst2_cnt", {32'b0, cnt_v[0]}, 64'h0);
    in_full = 1'b0;
    push(HA, 32'd5, 0); push(HB, 32'd6, 0); push(HA, 32'hFFFF_FFFF, 1);
    wr(1, 32'd5, 1, 32'd6);
    wr(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
